pipe_stage_buf: RTL and testbench

Parametrised pipeline stage register with valid/ready flow control, a 2-entry skid buffer, synchronous flush and per-field saturating countdown ("Tnew-style") fields. It replaces hand-written stage registers between CPU pipeline stages (E→M, M→W). It carries an opaque payload plus CNT_N countdown fields, and adds stall/backpressure handling and optional in-place ageing. The hand-written registers lack both.

---
 rtl/pipe_stage_buf.sv | 166 ++++++++++++++++
 tb/tb_pipe_stage_buf.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and per-field saturating countdown fields.
module pipe_stage_buf #(
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned CNT_N       = 2,
    parameter int unsigned CNT_W       = 2,
    parameter int unsigned AGE_ON_HOLD = 0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [DATA_W-1:0]        in_data,
    input  logic [CNT_N*CNT_W-1:0]   in_cnt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [CNT_N*CNT_W-1:0]   out_cnt,
    output logic [1:0]               level
);

    localparam int unsigned CNT_TW = CNT_N * CNT_W;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [DATA_W-1:0]   main_data;
    logic [DATA_W-1:0]   main_data_nxt;
    logic [CNT_TW-1:0]   main_cnt;
    logic [CNT_TW-1:0]   main_cnt_nxt;
    logic [DATA_W-1:0]   skid_data;
    logic [DATA_W-1:0]   skid_data_nxt;
    logic [CNT_TW-1:0]   skid_cnt;
    logic [CNT_TW-1:0]   skid_cnt_nxt;
    logic [1:0]          level_nxt;
    logic                in_xfer;
    logic                out_xfer;

    // Decrement every field independently, sticking at zero.
    function automatic logic [CNT_TW-1:0] sat_dec(input logic [CNT_TW-1:0] x);
        logic [CNT_TW-1:0] r;
        r = x;
        for (int unsigned k = 0; k < CNT_N; k++) begin
            if (x[k*CNT_W +: CNT_W] != '0) begin
                r[k*CNT_W +: CNT_W] = x[k*CNT_W +: CNT_W] - CNT_W'(1);
            end
        end
        return r;
    endfunction

    // Ageing applied to an entry that stays buffered or moves skid->main.
    function automatic logic [CNT_TW-1:0] hold_age(input logic [CNT_TW-1:0] x);
        logic [CNT_TW-1:0] r;
        r = x;
        if (AGE_ON_HOLD != 0) begin
            r = sat_dec(x);
        end
        return r;
    endfunction

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;
    assign out_data = main_data;
    assign out_cnt  = main_cnt;

    // Next-state and next-register values; empty registers are forced to zero.
    always_comb begin
        state_nxt     = state;
        main_data_nxt = main_data;
        main_cnt_nxt  = main_cnt;
        skid_data_nxt = skid_data;
        skid_cnt_nxt  = skid_cnt;
        level_nxt     = 2'd0;

        unique case (state)
            EMPTY: begin
                if (in_xfer) begin
                    state_nxt     = ONE;
                    main_data_nxt = in_data;
                    main_cnt_nxt  = sat_dec(in_cnt);
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_data_nxt = in_data;
                    main_cnt_nxt  = sat_dec(in_cnt);
                end else if (out_xfer) begin
                    state_nxt     = EMPTY;
                    main_data_nxt = '0;
                    main_cnt_nxt  = '0;
                end else if (in_xfer) begin
                    state_nxt     = TWO;
                    main_cnt_nxt  = hold_age(main_cnt);
                    skid_data_nxt = in_data;
                    skid_cnt_nxt  = sat_dec(in_cnt);
                end else begin
                    main_cnt_nxt  = hold_age(main_cnt);
                end
            end
            TWO: begin
                if (out_xfer) begin
                    state_nxt     = ONE;
                    main_data_nxt = skid_data;
                    main_cnt_nxt  = hold_age(skid_cnt);
                    skid_data_nxt = '0;
                    skid_cnt_nxt  = '0;
                end else begin
                    main_cnt_nxt  = hold_age(main_cnt);
                    skid_cnt_nxt  = hold_age(skid_cnt);
                end
            end
            default: begin
                state_nxt     = EMPTY;
                main_data_nxt = '0;
                main_cnt_nxt  = '0;
                skid_data_nxt = '0;
                skid_cnt_nxt  = '0;
            end
        endcase

        // Flush kills both entries and any same-cycle input.
        if (flush) begin
            state_nxt     = EMPTY;
            main_data_nxt = '0;
            main_cnt_nxt  = '0;
            skid_data_nxt = '0;
            skid_cnt_nxt  = '0;
        end

        unique case (state_nxt)
            ONE:     level_nxt = 2'd1;
            TWO:     level_nxt = 2'd2;
            default: level_nxt = 2'd0;
        endcase
    end

    // State, storage and registered status outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= EMPTY;
            main_data <= '0;
            main_cnt  <= '0;
            skid_data <= '0;
            skid_cnt  <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            level     <= 2'd0;
        end else begin
            state     <= state_nxt;
            main_data <= main_data_nxt;
            main_cnt  <= main_cnt_nxt;
            skid_data <= skid_data_nxt;
            skid_cnt  <= skid_cnt_nxt;
            out_valid <= (state_nxt != EMPTY);
            in_ready  <= (state_nxt != TWO);
            level     <= level_nxt;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: two instances (no ageing / ageing) share stimulus and
// are checked each cycle against a FIFO-list model plus hand-computed literals.
module tb_pipe_stage_buf;

    logic         clock;
    logic         reset;
    logic         flush;
    logic         in_valid;
    logic [127:0] in_data;
    logic [3:0]   in_cnt;
    logic         out_ready;

    logic         ov [2];
    logic         ir [2];
    logic [127:0] od [2];
    logic [3:0]   oc [2];
    logic [1:0]   lv [2];

    int n_checks = 0;
    int n_errors = 0;

    // Model: per instance, an ordered list of up to two buffered entries.
    int           m_n [2] = '{0, 0};
    logic [127:0] m_d [2][2];
    logic [3:0]   m_c [2][2];

    pipe_stage_buf #(.DATA_W(128), .CNT_N(2), .CNT_W(2), .AGE_ON_HOLD(0)) dut0 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[0]), .in_data(in_data), .in_cnt(in_cnt),
        .out_valid(ov[0]), .out_ready(out_ready), .out_data(od[0]), .out_cnt(oc[0]),
        .level(lv[0])
    );

    pipe_stage_buf #(.DATA_W(128), .CNT_N(2), .CNT_W(2), .AGE_ON_HOLD(1)) dut1 (
        .clock(clock), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(ir[1]), .in_data(in_data), .in_cnt(in_cnt),
        .out_valid(ov[1]), .out_ready(out_ready), .out_data(od[1]), .out_cnt(oc[1]),
        .level(lv[1])
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [3:0] dec2(input logic [3:0] x);
        int hi;
        int lo;
        hi = int'(x[3:2]);
        lo = int'(x[1:0]);
        hi = (hi == 0) ? 0 : hi - 1;
        lo = (lo == 0) ? 0 : lo - 1;
        return {2'(hi), 2'(lo)};
    endfunction

    // Model advance at each rising edge: pop, age survivors, push.
    always @(posedge clock) begin
        bit ix;
        bit ox;
        int n;
        for (int k = 0; k < 2; k++) begin
            ix = in_valid && (m_n[k] < 2);
            ox = out_ready && (m_n[k] > 0);
            if (reset || flush) begin
                m_n[k] = 0;
            end else begin
                n = m_n[k];
                if (ox) begin
                    m_d[k][0] = m_d[k][1];
                    m_c[k][0] = m_c[k][1];
                    n = n - 1;
                end
                if (k == 1) begin
                    for (int j = 0; j < n; j++) m_c[k][j] = dec2(m_c[k][j]);
                end
                if (ix) begin
                    m_d[k][n] = in_data;
                    m_c[k][n] = dec2(in_cnt);
                    n = n + 1;
                end
                m_n[k] = n;
            end
        end
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("m_out_valid%0d", k), 128'(ov[k]), 128'(m_n[k] > 0));
            chk($sformatf("m_out_data%0d", k), od[k], (m_n[k] > 0) ? m_d[k][0] : 128'd0);
            chk($sformatf("m_out_cnt%0d", k), 128'(oc[k]), (m_n[k] > 0) ? 128'(m_c[k][0]) : 128'd0);
            chk($sformatf("m_level%0d", k), 128'(lv[k]), 128'(m_n[k]));
            chk($sformatf("m_in_ready%0d", k), 128'(ir[k]), 128'(m_n[k] < 2));
        end
    endtask

    // Drive one cycle's inputs, let one edge pass, then compare at the falling edge.
    task automatic tick(input logic iv, input logic [127:0] id, input logic [3:0] ic,
                        input logic ordy, input logic fl, input logic rst);
        in_valid  = iv;
        in_data   = id;
        in_cnt    = ic;
        out_ready = ordy;
        flush     = fl;
        reset     = rst;
        @(negedge clock);
        compare_all();
    endtask

    localparam logic [127:0] D0 = 128'h0123_4567_89ab_cdef_0011_2233_4455_6677;
    localparam logic [127:0] D1 = 128'hdead_beef_0000_0001_cafe_f00d_1234_5678;
    localparam logic [127:0] D2 = 128'h1;
    localparam logic [127:0] D3 = 128'hffff_ffff_ffff_ffff_ffff_ffff_ffff_fffe;
    localparam logic [127:0] A  = 128'haaaa;
    localparam logic [127:0] B  = 128'hbbbb;
    localparam logic [127:0] C  = 128'hcccc;
    localparam logic [127:0] X  = 128'h5555_0000_7777;
    localparam logic [127:0] P  = 128'h1111;
    localparam logic [127:0] Q  = 128'h2222;
    localparam logic [127:0] R  = 128'h3333;

    initial begin
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_cnt = '0; out_ready = 1'b0;

        tick(0, 0, 0, 0, 0, 1);
        chk("rst_out_valid", 128'(ov[0]), 0);
        chk("rst_out_data", od[0], 0);
        chk("rst_level", 128'(lv[0]), 0);
        chk("rst_in_ready", 128'(ir[0]), 1);

        // Streaming at full rate
        tick(1, D0, 4'b10_01, 1, 0, 0);
        chk("st_d0", od[0], D0);
        chk("st_c0", 128'(oc[0]), 128'(4'b01_00));
        tick(1, D1, 4'b00_11, 1, 0, 0);
        chk("st_d1", od[0], D1);
        chk("st_c1", 128'(oc[0]), 128'(4'b00_10));
        tick(1, D2, 4'b11_10, 1, 0, 0);
        chk("st_c2", 128'(oc[0]), 128'(4'b10_01));
        tick(1, D3, 4'b00_00, 1, 0, 0);
        chk("st_d3", od[0], D3);
        chk("st_c3", 128'(oc[0]), 0);
        tick(0, 0, 0, 1, 0, 0);
        chk("st_drain", 128'(ov[0]), 0);

        // Backpressure
        tick(1, A, 4'b10_10, 0, 0, 0);
        chk("bp_a", od[0], A);
        tick(1, B, 4'b10_10, 0, 0, 0);
        chk("bp_level2", 128'(lv[0]), 2);
        chk("bp_ready0", 128'(ir[0]), 0);
        chk("bp_hold_a", od[0], A);
        tick(1, C, 4'b10_10, 0, 0, 0);
        chk("bp_c_held", 128'(lv[0]), 2);
        tick(1, C, 4'b10_10, 1, 0, 0);
        chk("bp_b", od[0], B);
        chk("bp_recover", 128'(ir[0]), 1);
        tick(1, C, 4'b10_10, 1, 0, 0);
        chk("bp_c", od[0], C);
        tick(0, 0, 0, 1, 0, 0);
        chk("bp_empty", 128'(lv[0]), 0);

        // Ageing on hold
        tick(1, X, 4'b11_11, 0, 0, 0);
        chk("age1_c0", 128'(oc[1]), 128'(4'b10_10));
        chk("age0_c0", 128'(oc[0]), 128'(4'b10_10));
        tick(0, 0, 0, 0, 0, 0);
        chk("age1_c1", 128'(oc[1]), 128'(4'b01_01));
        chk("age0_c1", 128'(oc[0]), 128'(4'b10_10));
        tick(0, 0, 0, 0, 0, 0);
        chk("age1_c2", 128'(oc[1]), 0);
        tick(0, 0, 0, 0, 0, 0);
        chk("age1_sat", 128'(oc[1]), 0);
        chk("age0_frozen", 128'(oc[0]), 128'(4'b10_10));
        tick(0, 0, 0, 1, 0, 0);

        // Flush discarding a same-cycle input transfer in ONE
        tick(1, P, 4'b00_11, 0, 0, 0);
        tick(1, Q, 4'b00_11, 0, 1, 0);
        chk("fl1_valid", 128'(ov[0]), 0);
        chk("fl1_level", 128'(lv[0]), 0);

        // Flush in TWO with input presented
        tick(1, P, 4'b00_11, 0, 0, 0);
        tick(1, Q, 4'b00_11, 0, 0, 0);
        chk("fl2_pre_level", 128'(lv[0]), 2);
        tick(1, R, 4'b00_11, 0, 1, 0);
        chk("fl2_valid", 128'(ov[0]), 0);
        chk("fl2_data", od[0], 0);
        chk("fl2_level", 128'(lv[0]), 0);
        chk("fl2_ready", 128'(ir[0]), 1);
        tick(0, 0, 0, 0, 0, 0);
        chk("fl2_no_r", 128'(ov[0]), 0);

        // Reset and flush together in TWO, then a single push
        tick(1, P, 4'b00_11, 0, 0, 0);
        tick(1, Q, 4'b00_11, 0, 0, 0);
        tick(1, R, 4'b00_11, 0, 1, 1);
        chk("rf_valid", 128'(ov[0]), 0);
        chk("rf_level", 128'(lv[0]), 0);
        chk("rf_ready", 128'(ir[0]), 1);
        tick(1, X, 4'b01_10, 0, 0, 0);
        chk("rf_x_data", od[0], X);
        chk("rf_x_cnt", 128'(oc[0]), 128'(4'b00_01));
        tick(0, 0, 0, 1, 0, 0);

        // Mixed traffic, model-checked each cycle
        for (int i = 0; i < 300; i++) begin
            tick(1'($urandom_range(0, 1)),
                 {$urandom, $urandom, $urandom, $urandom},
                 4'($urandom_range(0, 15)),
                 1'($urandom_range(0, 3) != 0),
                 1'($urandom_range(0, 31) == 0),
                 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
